// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : 640x480@60 Hz raster timing constants, derived sync window
//                bounds, rgb field positions and PMOD pin reset value.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

  localparam int CNT_W = 10;

  // Base raster timing, in pixel clocks (horizontal) and lines (vertical)
  localparam logic [CNT_W-1:0] H_ACTIVE = 10'd640;
  localparam logic [CNT_W-1:0] H_FP     = 10'd16;
  localparam logic [CNT_W-1:0] H_SYNC   = 10'd96;
  localparam logic [CNT_W-1:0] H_BP     = 10'd48;
  localparam logic [CNT_W-1:0] V_ACTIVE = 10'd480;
  localparam logic [CNT_W-1:0] V_FP     = 10'd10;
  localparam logic [CNT_W-1:0] V_SYNC   = 10'd2;
  localparam logic [CNT_W-1:0] V_BP     = 10'd33;

  // Derived totals and half-open sync windows [START, END)
  localparam logic [CNT_W-1:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [CNT_W-1:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] HS_START = H_ACTIVE + H_FP;
  localparam logic [CNT_W-1:0] HS_END   = HS_START + H_SYNC;
  localparam logic [CNT_W-1:0] VS_START = V_ACTIVE + V_FP;
  localparam logic [CNT_W-1:0] VS_END   = VS_START + V_SYNC;

  // Bit positions inside the 6-bit {R[1:0],G[1:0],B[1:0]} colour word
  localparam int RGB_R1 = 5;
  localparam int RGB_R0 = 4;
  localparam int RGB_G1 = 3;
  localparam int RGB_G0 = 2;
  localparam int RGB_B1 = 1;
  localparam int RGB_B0 = 0;

  // Pins idle: both syncs deasserted (high), colour black
  localparam logic [7:0] UO_RESET = 8'b1000_1000;

endpackage
`default_nettype wire

// File: rtl/vga_pmod_pack.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pmod_pack
//  Description : Registered TinyVGA PMOD output stage. Blanks colour outside
//                the active area and registers sync and colour on the same
//                edge so they stay aligned at the pins.
//                Pin order (bit7..0): {hsync,B0,G0,R0,vsync,B1,G1,R1}
//  Revision    : 1.0  initial release
// ============================================================================
module vga_pmod_pack
  import vga_timing_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_raw,
  input  logic       vsync_raw,
  input  logic       active,
  input  logic [5:0] rgb_in,
  output logic [7:0] uo_out
);

  logic [5:0] colour;
  logic [7:0] uo_d;
  logic [7:0] uo_q;

  // Gate colour to black in blanking and scatter bits onto the PMOD pin order
  always_comb begin
    colour = active ? rgb_in : 6'd0;
    uo_d   = {hsync_raw,
              colour[RGB_B0], colour[RGB_G0], colour[RGB_R0],
              vsync_raw,
              colour[RGB_B1], colour[RGB_G1], colour[RGB_R1]};
  end

  // Single output register: all eight pins change on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_q <= UO_RESET;
    end else begin
      uo_q <= uo_d;
    end
  end

  assign uo_out = uo_q;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : 640x480@60 Hz raster timing source. Free-running h/v
//                counters, combinational x/y/active/next_frame decodes and
//                a registered PMOD pin driver.
//                Optional macro VGA_FRAME_CNT_EN: when defined, frame_cnt
//                counts next_frame pulses (mod 256); otherwise it is tied 0.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active,
  output logic             next_frame,
  input  logic [5:0]       rgb_in,
  output logic [7:0]       uo_out,
  output logic [7:0]       frame_cnt
);

  logic [CNT_W-1:0] h_cnt_d, h_cnt_q;
  logic [CNT_W-1:0] v_cnt_d, v_cnt_q;
  logic             hsync_raw;
  logic             vsync_raw;

  // Next-count logic: h wraps every line, v advances only on the h wrap
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_TOTAL - 10'd1) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_TOTAL - 10'd1) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end
  end

  // Raster position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Position decodes, valid in the same cycle as the counters
  always_comb begin
    x          = h_cnt_q;
    y          = v_cnt_q;
    active     = (h_cnt_q < H_ACTIVE) && (v_cnt_q < V_ACTIVE);
    next_frame = (h_cnt_q == '0) && (v_cnt_q == V_ACTIVE);
    hsync_raw  = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    vsync_raw  = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_d, frame_cnt_q;

  // Advance once per frame, on the vblank-start pulse
  always_comb begin
    frame_cnt_d = frame_cnt_q + {7'd0, next_frame};
  end

  // Frame counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 8'd0;
`endif

  vga_pmod_pack u_pmod_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .active    (active),
    .rgb_in    (rgb_in),
    .uo_out    (uo_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Scoreboard bench for vga_timing_gen. A driver advances a
//                linear raster position model and queues the expected
//                outputs; a monitor pops and compares after every edge.
//                Long idle stretches are skipped by relocating the counters.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int LINE  = 800;
  localparam int LINES = 525;
  localparam int FRAME = LINE * LINES;
  localparam int VBLK  = 480 * LINE;
`ifdef VGA_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       nf;
    logic [7:0] uo;
    logic [7:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] rgb_in;
  logic [9:0] x, y;
  logic       active, next_frame;
  logic [7:0] uo_out, frame_cnt;

  exp_t       sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         p        = 0;
  int         m_fc     = 0;
  logic       hold_white = 1'b0;
  logic [9:0] jump_h, jump_v;

  vga_timing_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .y          (y),
    .active     (active),
    .next_frame (next_frame),
    .rgb_in     (rgb_in),
    .uo_out     (uo_out),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  // Pin image produced by the output register for raster position pos
  function automatic logic [7:0] pins(int pos, logic [5:0] rgb);
    int hx, vy;
    logic [5:0] c;
    logic hs, vs;
    hx = pos % LINE;
    vy = pos / LINE;
    c  = (hx < 640 && vy < 480) ? rgb : 6'd0;
    hs = !(hx >= 656 && hx < 752);
    vs = !(vy >= 490 && vy < 492);
    return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
  endfunction

  // Drive a colour and queue what the DUT must show after the next edge
  task automatic do_cycle();
    exp_t e;
    logic [7:0] uo_next;
    rgb_in = hold_white ? 6'h3f : 6'($urandom);
    if (!rst_n) begin
      p = 0; m_fc = 0;
      e.x = 10'd0; e.y = 10'd0; e.active = 1'b1; e.nf = 1'b0;
      e.uo = 8'h88; e.fc = 8'd0;
    end else begin
      uo_next = pins(p, rgb_in);
      if (p == VBLK) m_fc = (m_fc + 1) % 256;
      p = (p + 1) % FRAME;
      e.x      = 10'(p % LINE);
      e.y      = 10'(p / LINE);
      e.active = (p % LINE < 640) && (p / LINE < 480);
      e.nf     = (p == VBLK);
      e.uo     = uo_next;
      e.fc     = FC_EN ? 8'(m_fc) : 8'd0;
    end
    sb_q.push_back(e);
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(negedge clk);
      do_cycle();
    end
  endtask

  // Relocate the raster counters between edges to skip idle lines
  task automatic jump(int h, int v);
    jump_h = 10'(h);
    jump_v = 10'(v);
    force dut.h_cnt_q = jump_h;
    force dut.v_cnt_q = jump_v;
    #1;
    release dut.h_cnt_q;
    release dut.v_cnt_q;
    p = v * LINE + h;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (x !== e.x || y !== e.y || active !== e.active ||
            next_frame !== e.nf || uo_out !== e.uo || frame_cnt !== e.fc) begin
          failures++;
          $display("FAIL sb t=%0t: got x=%0d y=%0d act=%0b nf=%0b uo=%h fc=%0d expected x=%0d y=%0d act=%0b nf=%0b uo=%h fc=%0d",
                   $time, x, y, active, next_frame, uo_out, frame_cnt,
                   e.x, e.y, e.active, e.nf, e.uo, e.fc);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    rgb_in = 6'd0;
    run(5);
    check("reset_uo", {24'd0, uo_out}, 32'h88);

    // Release: counting restarts from (0,0)
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle();
    run(1700);

    // End of visible area, vblank pulse and vsync with colour held white
    @(negedge clk);
    hold_white = 1'b1;
    jump(790, 478);
    do_cycle();
    run(12500);
    hold_white = 1'b0;

    // Frame wrap: no pulse at (0,0)
    @(negedge clk);
    jump(790, 523);
    do_cycle();
    run(2000);

    // Random raster positions
    repeat (3) begin
      @(negedge clk);
      jump($urandom_range(0, 798), $urandom_range(0, 524));
      do_cycle();
      run(300);
    end

    // Mid-frame asynchronous reset at (300,200)
    @(negedge clk);
    jump(295, 200);
    do_cycle();
    run(4);
    @(negedge clk);
    check("pre_reset_x", {22'd0, x}, 32'd300);
    rst_n = 1'b0;
    #1;
    check("async_x", {22'd0, x}, 32'd0);
    check("async_y", {22'd0, y}, 32'd0);
    check("async_uo", {24'd0, uo_out}, 32'h88);
    check("async_fc", {24'd0, frame_cnt}, 32'd0);
    do_cycle();
    run(2);
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle();
    run(1000);

    // Three vblank pulses since reset
    repeat (3) begin
      @(negedge clk);
      jump(795, 479);
      do_cycle();
      run(20);
    end
    check("fc_three", {24'd0, frame_cnt}, FC_EN ? 32'd3 : 32'd0);

    // Frame counter wraps 255 -> 0
`ifdef VGA_FRAME_CNT_EN
    @(negedge clk);
    force dut.frame_cnt_q = 8'd255;
    #1;
    release dut.frame_cnt_q;
    m_fc = 255;
    do_cycle();
`endif
    @(negedge clk);
    jump(795, 479);
    do_cycle();
    run(20);
    check("fc_wrap", {24'd0, frame_cnt}, 32'd0);

    @(posedge clk);
    #3;
    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
